// File: rtl/seg_pkg.sv
// Shared constants for the eight-digit seven-segment scan driver.
// Segment patterns are active-low, bit 6 = a ... bit 0 = g.
package seg_pkg;
  localparam int NUM_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;
endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment decode.
// Ports: nib (4-bit hex digit in), seg (7-bit pattern out, a..g).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed 7-seg scanner with valid/ready load and
// frame-aligned display update. Ports: clk, rst_n (async, active-low),
// in_valid/in_ready/in_data (32-bit, 8 nibbles), en_mask (per-digit),
// an (active-low digit select), seg (active-low a..g).
// Optional: SEG_BLANK_LEADING_ZERO_EN blanks leading zero digits.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  input  logic [NUM_DIGITS-1:0] en_mask,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   pend;
  logic [31:0]   disp;
  logic          pend_v;
  logic          tick;
  logic          frame_end;
  logic          xfer;
  logic [3:0]    nib;
  logic [6:0]    dec;
  logic          lead_blank;

  assign tick      = (cnt == CMAX);
  assign frame_end = tick && (idx == 3'd7);
  assign in_ready  = ~pend_v;
  assign xfer      = in_valid && ~pend_v;
  assign nib       = disp[{idx, 2'b00} +: 4];

  seg_hex_decode u_dec (
    .nib (nib),
    .seg (dec)
  );

`ifdef SEG_BLANK_LEADING_ZERO_EN
  // Highest nonzero nibble; digit 0 is never blanked.
  logic [2:0] top;
  always_comb begin
    top = 3'd0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (disp[4*k +: 4] != 4'h0) top = 3'(k);
    end
  end
  assign lead_blank = (idx > top);
`else
  assign lead_blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 3'd0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx + 3'd1;
    end
  end

  // Display only changes at a frame boundary so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= 32'h0;
      disp   <= 32'h0;
      pend_v <= 1'b0;
    end else if (frame_end && pend_v) begin
      disp   <= pend;
      pend_v <= 1'b0;
    end else if (xfer) begin
      pend   <= in_data;
      pend_v <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 8'hFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= en_mask[idx] ? ~(8'd1 << idx) : 8'hFF;
      seg <= (!en_mask[idx] || lead_blank) ? SEG_BLANK : dec;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench: two scanners (CLK_DIV 4 and 1) against a
// cycle-count reference model; directed steps then random traffic.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv [2];
  logic [31:0] id [2];
  logic [7:0]  em [2];
  logic        rdy [2];
  logic [7:0]  an [2];
  logic [6:0]  sg [2];

  int tests = 0;
  int fails = 0;

  localparam logic [6:0] HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  always #5 clk = ~clk;

  seg_scan_driver #(.CLK_DIV(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]),
    .in_data(id[0]), .en_mask(em[0]), .an(an[0]), .seg(sg[0]));

  seg_scan_driver #(.CLK_DIV(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]),
    .in_data(id[1]), .en_mask(em[1]), .an(an[1]), .seg(sg[1]));

  // Reference model: slot = floor(edges / DIV) mod 8,
  // frame end = last edge of every 8*DIV edge window.
  int          n [2];
  logic [31:0] mdisp [2];
  logic [31:0] mpend [2];
  bit          mpv [2];
  logic [7:0]  ean [2];
  logic [6:0]  eseg [2];

  function automatic int divof(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic [6:0] digit(logic [31:0] v, int k);
    int h;
    logic [3:0] nb;
    nb = 4'((v >> (4 * k)) & 32'hF);
    h = 0;
    for (int j = 0; j < 8; j++) if (((v >> (4 * j)) & 32'hF) != 0) h = j;
`ifdef SEG_BLANK_LEADING_ZERO_EN
    if (k > h) return 7'h7F;
`endif
    return HEX[nb];
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int s;
    bit fe;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        n[i] = 0; mdisp[i] = 0; mpend[i] = 0; mpv[i] = 0;
        ean[i] = 8'hFF; eseg[i] = 7'h7F;
      end else begin
        s  = (n[i] / divof(i)) % 8;
        fe = (n[i] % (8 * divof(i))) == (8 * divof(i) - 1);
        ean[i]  = em[i][s] ? ~(8'd1 << s) : 8'hFF;
        eseg[i] = em[i][s] ? digit(mdisp[i], s) : 7'h7F;
        if (fe && mpv[i]) begin
          mdisp[i] = mpend[i];
          mpv[i] = 0;
        end else if (iv[i] && !mpv[i]) begin
          mpend[i] = id[i];
          mpv[i] = 1;
        end
        n[i]++;
      end
    end
  end

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("an[%0d]", i), an[i], ean[i]);
      chk($sformatf("seg[%0d]", i), {1'b0, sg[i]}, {1'b0, eseg[i]});
      chk($sformatf("rdy[%0d]", i), {7'b0, rdy[i]}, {7'b0, ~mpv[i]});
    end
  endtask

  task automatic step(int k);
    for (int c = 0; c < k; c++) begin
      @(posedge clk);
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic reset_vals(string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_an"}, an[i], 8'hFF);
      chk({tag, "_seg"}, {1'b0, sg[i]}, 8'h7F);
      chk({tag, "_rdy"}, {7'b0, rdy[i]}, 8'h01);
    end
  endtask

  initial begin
    bit hit;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 0; id[i] = 0; em[i] = 8'hFF;
    end
    #23;
    reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    // Idle scan: blank for one cycle then walking digit, all zeros.
    step(40);

    // Load 0123ABCD on CLK_DIV=1 then offer FFFFFFFF while pending.
    id[1] = 32'h0123ABCD; iv[1] = 1;
    step(1);
    id[1] = 32'hFFFFFFFF;
    step(2);
    iv[1] = 0;
    step(20);

    // CLK_DIV=4: transfer lands exactly on a frame end.
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if ((n[0] % 32) == 31 && !mpv[0]) hit = 1;
      else step(1);
    end
    tests++;
    assert (hit) else begin
      fails++;
      $error("FAIL fe_wait observed=0 expected=1");
    end
    id[0] = 32'h89ABCDEF; iv[0] = 1;
    step(1);
    iv[0] = 0;
    step(70);

    // Partial enable mask.
    em[0] = 8'h0F; em[1] = 8'h0F;
    step(40);
    em[0] = 8'hFF; em[1] = 8'hFF;

    // Leading-zero candidates.
    id[1] = 32'h00000A05; iv[1] = 1;
    step(1);
    iv[1] = 0;
    step(20);
    id[1] = 32'h0; iv[1] = 1;
    step(1);
    iv[1] = 0;
    step(20);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        iv[i] = ($urandom_range(3) == 0);
        id[i] = $urandom();
        if ($urandom_range(3) == 0) id[i] = id[i] >> (4 * $urandom_range(7));
        em[i] = ($urandom_range(4) == 0) ? 8'($urandom()) : 8'hFF;
      end
      step(1);
    end

    // Asynchronous reset mid-frame with data pending.
    id[0] = 32'h12345678; iv[0] = 1;
    id[1] = 32'h87654321; iv[1] = 1;
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    reset_vals("arst");
    iv[0] = 0; iv[1] = 0;
    @(negedge clk);
    reset_vals("arst_hold");
    rst_n = 1'b1;
    step(80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
